rob_multibank: RTL and testbench
================================

Name: rob_multibank

Overview:
- Parametrised reorder buffer for the out-of-order core; successor to the fixed two-wide ROB.
- Holds renamed destinations in program order as rows of WIDTH slots, one slot per bank. Each slot is marked done on writeback.
- Commits whole rows in order, up to WIDTH per cycle.
- New over the previous generation: configurable width/depth, per-slot exception flags with precise partial-row commit, and an external flush for misprediction recovery.

Parameters:
- WIDTH, 2, dispatch/writeback/commit lanes (banks); power of two, >=1
- DEPTH, 16, rows per ROB; power of two, >=2
- PHYS_ADDR_W, 6, physical register index width
- ROW_W, $clog2(DEPTH), row address width (derived)
- BANK_W, max(1,$clog2(WIDTH)), bank address width (derived)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- dispatch_en  input  WIDTH  per-lane dispatch valid
- dispatch_phys_rd  input  WIDTH x PHYS_ADDR_W  new physical rd
- dispatch_arch_rd  input  WIDTH x 5  architectural rd
- dispatch_rob_addr  output  ROW_W  row allocated this cycle (= tail)
- dispatch_bank_addr  output  WIDTH x BANK_W  constant lane index i
- full  output  1  no free row
- writeback_en  input  WIDTH  per-lane completion
- writeback_rob_addr  input  WIDTH x ROW_W  completing row
- writeback_bank_addr  input  WIDTH x BANK_W  completing slot
- writeback_exc  input  WIDTH  completion raised an exception
- flush  input  1  squash all in-flight entries
- commit_en  output  WIDTH  slot retires this cycle
- commit_phys_rd  output  WIDTH x PHYS_ADDR_W  retiring physical rd
- commit_arch_rd  output  WIDTH x 5  retiring architectural rd
- exc_valid  output  1  head slot retires with exception
- exc_rob_addr  output  ROW_W  row of excepting slot
- exc_bank_addr  output  BANK_W  bank of excepting slot

Behaviour:
- Pointers: head and tail are ROW_W+1 bits, with the MSB as the wrap bit. Empty when head==tail. full when the indices are equal and the wrap bits differ.
- Reset (rst low, async): head=tail=0; all valid/done/exc bits cleared. Outputs: full=0, commit_en=0, exc_valid=0, dispatch_rob_addr=0, exc_* = 0.
- Dispatch: if |dispatch_en && !full && !flush, row[tail] is written at the clock edge and tail increments.
  - Lanes with en=0 are stored valid=0 and need no writeback.
  - dispatch_rob_addr is combinational from tail.
  - Dispatch while full is ignored; the dispatcher must hold.
- Writeback: at the edge, sets done (and exc if writeback_exc) of slot (rob_addr, bank_addr).
  - Writes to unallocated rows or valid=0 slots are ignored.
  - Multiple lanes writing back the same cycle to different slots are all applied.
- Commit (combinational from registered state; takes effect at the edge): head row is ready when not empty and every valid slot is done.
  - No exception in the row: commit_en[i]=valid[i] for all i. head increments.
  - Exception present: let k be the lowest bank with valid, done and exc set.
    - commit_en[i]=valid[i] for i<k.
    - exc_valid=1 with exc_rob_addr=head index and exc_bank_addr=k.
    - At the edge, the ROB performs an internal flush.
  - Row not ready: all commit_en=0.
- Latency:
  - Writeback at edge N makes a row committable in the cycle after edge N.
  - Minimum dispatch-to-commit is 2 cycles when the writeback follows the dispatch edge.
- Flush (external or exception): at the edge, tail:=head, all valid bits cleared. Dispatch and writeback in the same cycle are dropped. Commit outputs in the flush cycle remain valid and are retired first.
- Simultaneous commit and dispatch: both are applied. full is based on registered pointers, so a row freed this cycle is usable next cycle.
- Reset asserted mid-operation clears state immediately, regardless of clk.

Decomposition:
- Shared package (rob_pkg): rob_slot_t {valid, done, exc, phys_rd, arch_rd}; default WIDTH/DEPTH constants; pointer typedef.
- Sub-module rob_bank: one instance per lane. Contains the DEPTH-entry slot array, dispatch write port, writeback done/exc set port, head read port and flush clear.
- Top level holds the pointers, ready/exception priority logic and full/empty.

Test Plan (WIDTH=2, DEPTH=4, PHYS_ADDR_W=6):
- Dispatch {en=11, phys 10/11, arch 1/2}, then writeback both slots of row 0 → next cycle commit_en=11, phys 10/11, arch 1/2. head=1.
- Dispatch 4 rows with no writeback → full=1; 5th dispatch ignored, tail unchanged. Write back row 0 → full drops the cycle after commit.
- Row 0 with en=01 only, writeback slot 0 → commit_en=01; slot 1 is never required.
- Writeback row 1 before row 0 → no commit until row 0 is done. Then rows 0 and 1 commit on consecutive cycles.
- Row 0 both done, bank 1 with writeback_exc=1 → commit_en=01, exc_valid=1, exc_rob_addr=0, exc_bank_addr=1. Next cycle empty, rows 1-2 squashed.
- flush with 3 rows in flight plus a simultaneous dispatch → next cycle empty, full=0, no commit. Dispatch then resumes at the old head address. Wrap-around covered by running more than 8 rows.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and default sizing for the multi-bank reorder buffer.
// Slot records are stored per bank; pointers carry an extra wrap bit above the row index.
package rob_pkg;

    localparam int ROB_WIDTH_DEF  = 2;
    localparam int ROB_DEPTH_DEF  = 16;
    localparam int ROB_PHYS_W_DEF = 6;
    localparam int ROB_ARCH_W     = 5;

    typedef logic [$clog2(ROB_DEPTH_DEF):0] rob_ptr_t;

    typedef struct packed {
        logic                      valid;
        logic                      done;
        logic                      exc;
        logic [ROB_PHYS_W_DEF-1:0] phys_rd;
        logic [ROB_ARCH_W-1:0]     arch_rd;
    } rob_slot_t;

endpackage

// File: rtl/rob_bank.sv
// One bank (lane) of the reorder buffer: DEPTH slots with a dispatch write port,
// per-row done/exception set inputs, a head read port and a global flush clear.
module rob_bank
    import rob_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH_DEF,
    parameter int ROW_W = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      disp_we,
    input  logic [ROW_W-1:0]          disp_row,
    input  logic                      disp_valid,
    input  logic [ROB_PHYS_W_DEF-1:0] disp_phys_rd,
    input  logic [ROB_ARCH_W-1:0]     disp_arch_rd,
    input  logic [DEPTH-1:0]          wb_done_set,
    input  logic [DEPTH-1:0]          wb_exc_set,
    input  logic                      head_clr,
    input  logic [ROW_W-1:0]          head_row,
    input  logic                      flush_clr,
    output rob_slot_t                 head_slot
);

    rob_slot_t slots_r [DEPTH];
    rob_slot_t new_slot_s;

    // Fresh slot image written at dispatch: not yet done, no exception.
    always_comb begin
        new_slot_s         = '0;
        new_slot_s.valid   = disp_valid;
        new_slot_s.done    = 1'b0;
        new_slot_s.exc     = 1'b0;
        new_slot_s.phys_rd = disp_phys_rd;
        new_slot_s.arch_rd = disp_arch_rd;
    end

    // Slot array update; flush beats dispatch beats retire beats writeback.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                slots_r[r] <= '0;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (flush_clr) begin
                    slots_r[r].valid <= 1'b0;
                end else if (disp_we && (disp_row == ROW_W'(r))) begin
                    slots_r[r] <= new_slot_s;
                end else if (head_clr && (head_row == ROW_W'(r))) begin
                    slots_r[r].valid <= 1'b0;
                end else if (slots_r[r].valid && wb_done_set[r]) begin
                    slots_r[r].done <= 1'b1;
                    slots_r[r].exc  <= slots_r[r].exc | wb_exc_set[r];
                end else begin
                    slots_r[r] <= slots_r[r];
                end
            end
        end
    end

    assign head_slot = slots_r[head_row];

endmodule

// File: rtl/rob_multibank.sv
// Multi-bank reorder buffer: rows of WIDTH slots allocated in order, committed in
// order once every valid slot is done, with precise partial-row exception commit.
module rob_multibank
    import rob_pkg::*;
#(
    parameter int WIDTH       = ROB_WIDTH_DEF,
    parameter int DEPTH       = ROB_DEPTH_DEF,
    parameter int PHYS_ADDR_W = ROB_PHYS_W_DEF,
    parameter int ROW_W       = $clog2(DEPTH),
    parameter int BANK_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [WIDTH-1:0]                     dispatch_en,
    input  logic [WIDTH-1:0][PHYS_ADDR_W-1:0]    dispatch_phys_rd,
    input  logic [WIDTH-1:0][ROB_ARCH_W-1:0]     dispatch_arch_rd,
    output logic [ROW_W-1:0]                     dispatch_rob_addr,
    output logic [WIDTH-1:0][BANK_W-1:0]         dispatch_bank_addr,
    output logic                                 full,
    input  logic [WIDTH-1:0]                     writeback_en,
    input  logic [WIDTH-1:0][ROW_W-1:0]          writeback_rob_addr,
    input  logic [WIDTH-1:0][BANK_W-1:0]         writeback_bank_addr,
    input  logic [WIDTH-1:0]                     writeback_exc,
    input  logic                                 flush,
    output logic [WIDTH-1:0]                     commit_en,
    output logic [WIDTH-1:0][PHYS_ADDR_W-1:0]    commit_phys_rd,
    output logic [WIDTH-1:0][ROB_ARCH_W-1:0]     commit_arch_rd,
    output logic                                 exc_valid,
    output logic [ROW_W-1:0]                     exc_rob_addr,
    output logic [BANK_W-1:0]                    exc_bank_addr
);

    localparam logic [ROW_W:0] PTR_ONE = {{ROW_W{1'b0}}, 1'b1};
    localparam logic [DEPTH-1:0] ROW_ONE = {{(DEPTH-1){1'b0}}, 1'b1};

    logic [ROW_W:0]      head_r, tail_r, head_next_s, occupancy_s;
    logic [ROW_W-1:0]    head_idx_s, tail_idx_s;
    logic                empty_s, full_s, ready_s, exc_hit_s, exc_seen_s;
    logic                commit_row_s, flush_all_s, do_dispatch_s, wb_hit_s;
    logic [WIDTH-1:0]    commit_en_s, hit_vec_s, wb_alloc_s;
    logic [BANK_W-1:0]   exc_bank_s;
    rob_slot_t           head_slot_s [WIDTH];
    logic [DEPTH-1:0]    wb_done_s [WIDTH];
    logic [DEPTH-1:0]    wb_exc_s [WIDTH];

    assign head_idx_s  = head_r[ROW_W-1:0];
    assign tail_idx_s  = tail_r[ROW_W-1:0];
    assign occupancy_s = tail_r - head_r;
    assign empty_s     = (head_r == tail_r);
    assign full_s      = (head_idx_s == tail_idx_s) && (head_r[ROW_W] != tail_r[ROW_W]);

    // Head-row readiness and lowest excepting bank; banks at or above it are held back.
    always_comb begin
        ready_s    = !empty_s;
        hit_vec_s  = '0;
        exc_bank_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ready_s      = ready_s & (~head_slot_s[i].valid | head_slot_s[i].done);
            hit_vec_s[i] = head_slot_s[i].valid & head_slot_s[i].done & head_slot_s[i].exc;
        end
        for (int i = WIDTH - 1; i >= 0; i--) begin
            exc_bank_s = hit_vec_s[i] ? BANK_W'(i) : exc_bank_s;
        end
        exc_hit_s   = ready_s & (|hit_vec_s);
        exc_seen_s  = 1'b0;
        commit_en_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            exc_seen_s     = exc_seen_s | hit_vec_s[i];
            commit_en_s[i] = ready_s & head_slot_s[i].valid & ~exc_seen_s;
        end
    end

    assign commit_row_s  = ready_s & ~exc_hit_s;
    assign flush_all_s   = flush | exc_hit_s;
    assign do_dispatch_s = (|dispatch_en) & ~full_s & ~flush_all_s;
    assign head_next_s   = commit_row_s ? (head_r + PTR_ONE) : head_r;

    // Route each lane's writeback to its target bank, dropping squashed or stale rows.
    always_comb begin
        wb_hit_s = 1'b0;
        for (int b = 0; b < WIDTH; b++) begin
            wb_done_s[b] = '0;
            wb_exc_s[b]  = '0;
        end
        for (int l = 0; l < WIDTH; l++) begin
            wb_alloc_s[l] = {1'b0, writeback_rob_addr[l] - head_idx_s} < occupancy_s;
        end
        for (int l = 0; l < WIDTH; l++) begin
            for (int b = 0; b < WIDTH; b++) begin
                wb_hit_s     = writeback_en[l] & wb_alloc_s[l] & ~flush_all_s
                               & (writeback_bank_addr[l] == BANK_W'(b));
                wb_done_s[b] = wb_done_s[b] | ({DEPTH{wb_hit_s}} & (ROW_ONE << writeback_rob_addr[l]));
                wb_exc_s[b]  = wb_exc_s[b]
                               | ({DEPTH{wb_hit_s & writeback_exc[l]}} & (ROW_ONE << writeback_rob_addr[l]));
            end
        end
    end

    // Head/tail pointers; any flush collapses tail onto the post-commit head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r <= '0;
            tail_r <= '0;
        end else begin
            head_r <= head_next_s;
            if (flush_all_s) begin
                tail_r <= head_next_s;
            end else if (do_dispatch_s) begin
                tail_r <= tail_r + PTR_ONE;
            end else begin
                tail_r <= tail_r;
            end
        end
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_bank
        rob_bank #(
            .DEPTH (DEPTH),
            .ROW_W (ROW_W)
        ) u_bank (
            .clk          (clk),
            .rst          (rst),
            .disp_we      (do_dispatch_s),
            .disp_row     (tail_idx_s),
            .disp_valid   (dispatch_en[b]),
            .disp_phys_rd (ROB_PHYS_W_DEF'(dispatch_phys_rd[b])),
            .disp_arch_rd (dispatch_arch_rd[b]),
            .wb_done_set  (wb_done_s[b]),
            .wb_exc_set   (wb_exc_s[b]),
            .head_clr     (commit_row_s),
            .head_row     (head_idx_s),
            .flush_clr    (flush_all_s),
            .head_slot    (head_slot_s[b])
        );

        assign dispatch_bank_addr[b] = BANK_W'(b);
        assign commit_phys_rd[b]     = commit_en_s[b] ? PHYS_ADDR_W'(head_slot_s[b].phys_rd)
                                                      : {PHYS_ADDR_W{1'b0}};
        assign commit_arch_rd[b]     = commit_en_s[b] ? head_slot_s[b].arch_rd
                                                      : {ROB_ARCH_W{1'b0}};
    end

    assign dispatch_rob_addr = tail_idx_s;
    assign full              = full_s;
    assign commit_en         = commit_en_s;
    assign exc_valid         = exc_hit_s;
    assign exc_rob_addr      = exc_hit_s ? head_idx_s : {ROW_W{1'b0}};
    assign exc_bank_addr     = exc_hit_s ? exc_bank_s : {BANK_W{1'b0}};

endmodule

// File: tb/tb_rob_multibank.sv
// Scoreboard bench for rob_multibank (WIDTH=2, DEPTH=4): expected commit rows are
// queued at dispatch and popped when the ROB retires them.
module tb_rob_multibank;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       dispatch_en;
    logic [1:0][5:0]  dispatch_phys_rd;
    logic [1:0][4:0]  dispatch_arch_rd;
    logic [1:0]       dispatch_rob_addr;
    logic [1:0][0:0]  dispatch_bank_addr;
    logic             full;
    logic [1:0]       writeback_en;
    logic [1:0][1:0]  writeback_rob_addr;
    logic [1:0][0:0]  writeback_bank_addr;
    logic [1:0]       writeback_exc;
    logic             flush;
    logic [1:0]       commit_en;
    logic [1:0][5:0]  commit_phys_rd;
    logic [1:0][4:0]  commit_arch_rd;
    logic             exc_valid;
    logic [1:0]       exc_rob_addr;
    logic [0:0]       exc_bank_addr;

    typedef struct packed {
        logic [1:0]      en;
        logic [1:0][5:0] phys;
        logic [1:0][4:0] arch;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    rob_multibank #(.WIDTH(2), .DEPTH(4), .PHYS_ADDR_W(6)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .dispatch_en         (dispatch_en),
        .dispatch_phys_rd    (dispatch_phys_rd),
        .dispatch_arch_rd    (dispatch_arch_rd),
        .dispatch_rob_addr   (dispatch_rob_addr),
        .dispatch_bank_addr  (dispatch_bank_addr),
        .full                (full),
        .writeback_en        (writeback_en),
        .writeback_rob_addr  (writeback_rob_addr),
        .writeback_bank_addr (writeback_bank_addr),
        .writeback_exc       (writeback_exc),
        .flush               (flush),
        .commit_en           (commit_en),
        .commit_phys_rd      (commit_phys_rd),
        .commit_arch_rd      (commit_arch_rd),
        .exc_valid           (exc_valid),
        .exc_rob_addr        (exc_rob_addr),
        .exc_bank_addr       (exc_bank_addr)
    );

    function automatic logic [11:0] pmask(input logic [1:0] en);
        return {{6{en[1]}}, {6{en[0]}}};
    endfunction

    function automatic logic [9:0] amask(input logic [1:0] en);
        return {{5{en[1]}}, {5{en[0]}}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dispatch_en         = 2'b00;
        dispatch_phys_rd    = '0;
        dispatch_arch_rd    = '0;
        writeback_en        = 2'b00;
        writeback_rob_addr  = '0;
        writeback_bank_addr = '0;
        writeback_exc       = 2'b00;
        flush               = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        exp_q.delete();
    endtask

    task automatic dispatch(input logic [1:0] en, input logic [5:0] p0, input logic [5:0] p1,
                            input logic [4:0] a0, input logic [4:0] a1, input bit push);
        exp_t e;
        dispatch_en      = en;
        dispatch_phys_rd = {p1, p0};
        dispatch_arch_rd = {a1, a0};
        if (push) begin
            e.en   = en;
            e.phys = {p1, p0};
            e.arch = {a1, a0};
            exp_q.push_back(e);
        end
        step();
        dispatch_en = 2'b00;
    endtask

    task automatic wb(input logic [1:0] en, input logic [1:0] r0, input logic [1:0] r1,
                      input logic b0, input logic b1, input logic [1:0] exc);
        writeback_en        = en;
        writeback_rob_addr  = {r1, r0};
        writeback_bank_addr = {b1, b0};
        writeback_exc       = exc;
        step();
        writeback_en  = 2'b00;
        writeback_exc = 2'b00;
    endtask

    task automatic test_reset();
        dispatch(2'b11, 6'd1, 6'd2, 5'd1, 5'd2, 1'b0);
        n_tests++;
        if (dispatch_rob_addr !== 2'd1) begin
            n_fail++; $display("FAIL reset_pre_tail: got %0d want 1", dispatch_rob_addr);
        end
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        n_tests++;
        if ({dispatch_rob_addr, full, commit_en} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_async: got addr=%0d full=%b cen=%b want 0/0/00",
                               dispatch_rob_addr, full, commit_en);
        end
        n_tests++;
        if ({exc_valid, exc_rob_addr, exc_bank_addr} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_exc: got v=%b row=%0d bank=%0d want 0", exc_valid, exc_rob_addr, exc_bank_addr);
        end
        n_tests++;
        if (dispatch_bank_addr !== 2'b10) begin
            n_fail++; $display("FAIL bank_addr: got %b want 10", dispatch_bank_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        exp_t e;
        apply_reset();
        dispatch(2'b11, 6'd10, 6'd11, 5'd1, 5'd2, 1'b1);
        n_tests++;
        if ({dispatch_rob_addr, commit_en} !== 4'b0100) begin
            n_fail++; $display("FAIL basic_alloc: got addr=%0d cen=%b want 1/00", dispatch_rob_addr, commit_en);
        end
        wb(2'b11, 2'd0, 2'd0, 1'b0, 1'b1, 2'b00);
        e = exp_q.pop_front();
        n_tests++;
        if ({commit_en, commit_phys_rd & pmask(e.en), commit_arch_rd & amask(e.en), exc_valid} !==
            {e.en, e.phys & pmask(e.en), e.arch & amask(e.en), 1'b0}) begin
            n_fail++; $display("FAIL basic_commit: got en=%b phys=%h arch=%h exc=%b want en=%b phys=%h arch=%h",
                               commit_en, commit_phys_rd, commit_arch_rd, exc_valid, e.en, e.phys, e.arch);
        end
        dispatch(2'b01, 6'd12, 6'd0, 5'd3, 5'd0, 1'b1);
        wb(2'b01, 2'd1, 2'd0, 1'b0, 1'b0, 2'b00);
        e = exp_q.pop_front();
        n_tests++;
        if ({commit_en, commit_phys_rd & pmask(e.en), commit_arch_rd & amask(e.en)} !==
            {e.en, e.phys & pmask(e.en), e.arch & amask(e.en)}) begin
            n_fail++; $display("FAIL basic_row1: got en=%b phys=%h arch=%h want en=%b phys=%h arch=%h",
                               commit_en, commit_phys_rd, commit_arch_rd, e.en, e.phys, e.arch);
        end
    endtask

    task automatic test_full();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            dispatch(2'b11, 6'(20 + 2 * i), 6'(21 + 2 * i), 5'(i), 5'(i + 8), 1'b1);
        end
        n_tests++;
        if ({full, dispatch_rob_addr} !== 3'b100) begin
            n_fail++; $display("FAIL full_set: got full=%b addr=%0d want 1/0", full, dispatch_rob_addr);
        end
        dispatch(2'b11, 6'd63, 6'd63, 5'd31, 5'd31, 1'b0);
        n_tests++;
        if ({full, dispatch_rob_addr} !== 3'b100) begin
            n_fail++; $display("FAIL full_ignore: got full=%b addr=%0d want 1/0", full, dispatch_rob_addr);
        end
        wb(2'b11, 2'd0, 2'd0, 1'b0, 1'b1, 2'b00);
        e = exp_q.pop_front();
        n_tests++;
        if ({full, commit_en, commit_phys_rd & pmask(e.en), commit_arch_rd & amask(e.en)} !==
            {1'b1, e.en, e.phys & pmask(e.en), e.arch & amask(e.en)}) begin
            n_fail++; $display("FAIL full_commit0: got full=%b en=%b phys=%h arch=%h want 1 en=%b phys=%h arch=%h",
                               full, commit_en, commit_phys_rd, commit_arch_rd, e.en, e.phys, e.arch);
        end
        for (int r = 1; r < 4; r++) begin
            wb(2'b11, 2'(r), 2'(r), 1'b1, 1'b0, 2'b00);
            e = exp_q.pop_front();
            n_tests++;
            if ({full, commit_en, commit_phys_rd & pmask(e.en), commit_arch_rd & amask(e.en)} !==
                {1'b0, e.en, e.phys & pmask(e.en), e.arch & amask(e.en)}) begin
                n_fail++; $display("FAIL full_drain%0d: got full=%b en=%b phys=%h arch=%h want 0 en=%b phys=%h arch=%h",
                                   r, full, commit_en, commit_phys_rd, commit_arch_rd, e.en, e.phys, e.arch);
            end
        end
        step();
        n_tests++;
        if (commit_en !== 2'b00) begin
            n_fail++; $display("FAIL full_empty: got cen=%b want 00", commit_en);
        end
    endtask

    task automatic test_partial_row();
        exp_t e;
        apply_reset();
        dispatch(2'b01, 6'd20, 6'd21, 5'd3, 5'd4, 1'b1);
        wb(2'b01, 2'd0, 2'd0, 1'b0, 1'b0, 2'b00);
        e = exp_q.pop_front();
        n_tests++;
        if ({commit_en, commit_phys_rd & pmask(e.en), commit_arch_rd & amask(e.en)} !==
            {e.en, e.phys & pmask(e.en), e.arch & amask(e.en)}) begin
            n_fail++; $display("FAIL partial_commit: got en=%b phys=%h arch=%h want en=%b phys=%h arch=%h",
                               commit_en, commit_phys_rd, commit_arch_rd, e.en, e.phys, e.arch);
        end
        step();
        n_tests++;
        if ({commit_en, dispatch_rob_addr} !== 4'b0001) begin
            n_fail++; $display("FAIL partial_after: got cen=%b addr=%0d want 00/1", commit_en, dispatch_rob_addr);
        end
    endtask

    task automatic test_out_of_order();
        exp_t e;
        apply_reset();
        dispatch(2'b11, 6'd30, 6'd31, 5'd5, 5'd6, 1'b1);
        dispatch(2'b11, 6'd32, 6'd33, 5'd7, 5'd8, 1'b1);
        wb(2'b11, 2'd1, 2'd1, 1'b1, 1'b0, 2'b00);
        n_tests++;
        if (commit_en !== 2'b00) begin
            n_fail++; $display("FAIL ooo_hold: got cen=%b want 00", commit_en);
        end
        step();
        n_tests++;
        if (commit_en !== 2'b00) begin
            n_fail++; $display("FAIL ooo_hold2: got cen=%b want 00", commit_en);
        end
        wb(2'b11, 2'd0, 2'd0, 1'b1, 1'b0, 2'b00);
        for (int r = 0; r < 2; r++) begin
            e = exp_q.pop_front();
            n_tests++;
            if ({commit_en, commit_phys_rd & pmask(e.en), commit_arch_rd & amask(e.en)} !==
                {e.en, e.phys & pmask(e.en), e.arch & amask(e.en)}) begin
                n_fail++; $display("FAIL ooo_row%0d: got en=%b phys=%h arch=%h want en=%b phys=%h arch=%h",
                                   r, commit_en, commit_phys_rd, commit_arch_rd, e.en, e.phys, e.arch);
            end
            step();
        end
        n_tests++;
        if (commit_en !== 2'b00) begin
            n_fail++; $display("FAIL ooo_empty: got cen=%b want 00", commit_en);
        end
    endtask

    task automatic test_exception();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            dispatch(2'b11, 6'(40 + 2 * i), 6'(41 + 2 * i), 5'(9 + 2 * i), 5'(10 + 2 * i), 1'b1);
        end
        wb(2'b11, 2'd0, 2'd0, 1'b0, 1'b1, 2'b10);
        e = exp_q.pop_front();
        e.en = 2'b01;
        n_tests++;
        if ({commit_en, commit_phys_rd & pmask(e.en), commit_arch_rd & amask(e.en)} !==
            {e.en, e.phys & pmask(e.en), e.arch & amask(e.en)}) begin
            n_fail++; $display("FAIL exc1_commit: got en=%b phys=%h arch=%h want en=%b phys=%h arch=%h",
                               commit_en, commit_phys_rd, commit_arch_rd, e.en, e.phys, e.arch);
        end
        n_tests++;
        if ({exc_valid, exc_rob_addr, exc_bank_addr} !== 4'b1001) begin
            n_fail++; $display("FAIL exc1_report: got v=%b row=%0d bank=%0d want 1/0/1", exc_valid, exc_rob_addr, exc_bank_addr);
        end
        exp_q.delete();
        step();
        n_tests++;
        if ({commit_en, exc_valid, full, dispatch_rob_addr} !== 6'b000000) begin
            n_fail++; $display("FAIL exc1_flushed: got cen=%b exc=%b full=%b addr=%0d want 00/0/0/0",
                               commit_en, exc_valid, full, dispatch_rob_addr);
        end
        wb(2'b11, 2'd1, 2'd1, 1'b0, 1'b1, 2'b00);
        n_tests++;
        if (commit_en !== 2'b00) begin
            n_fail++; $display("FAIL exc1_squashed: got cen=%b want 00", commit_en);
        end
        dispatch(2'b11, 6'd50, 6'd51, 5'd15, 5'd16, 1'b1);
        wb(2'b11, 2'd0, 2'd0, 1'b0, 1'b1, 2'b01);
        e = exp_q.pop_front();
        n_tests++;
        if ({commit_en, exc_valid, exc_rob_addr, exc_bank_addr} !== 6'b001000) begin
            n_fail++; $display("FAIL exc0_report: got cen=%b v=%b row=%0d bank=%0d want 00/1/0/0 (row phys %h)",
                               commit_en, exc_valid, exc_rob_addr, exc_bank_addr, e.phys);
        end
        exp_q.delete();
        step();
        n_tests++;
        if ({exc_valid, dispatch_rob_addr} !== 3'b000) begin
            n_fail++; $display("FAIL exc0_flushed: got exc=%b addr=%0d want 0/0", exc_valid, dispatch_rob_addr);
        end
    endtask

    task automatic test_flush();
        exp_t e;
        apply_reset();
        dispatch(2'b11, 6'd1, 6'd2, 5'd1, 5'd2, 1'b1);
        wb(2'b11, 2'd0, 2'd0, 1'b0, 1'b1, 2'b00);
        e = exp_q.pop_front();
        n_tests++;
        if ({commit_en, commit_phys_rd & pmask(e.en)} !== {e.en, e.phys & pmask(e.en)}) begin
            n_fail++; $display("FAIL flush_pre: got en=%b phys=%h want en=%b phys=%h", commit_en, commit_phys_rd, e.en, e.phys);
        end
        for (int i = 0; i < 3; i++) begin
            dispatch(2'b11, 6'(3 + i), 6'(7 + i), 5'(i), 5'(i), 1'b1);
        end
        n_tests++;
        if (dispatch_rob_addr !== 2'd0) begin
            n_fail++; $display("FAIL flush_fill: got addr=%0d want 0", dispatch_rob_addr);
        end
        flush = 1'b1;
        dispatch(2'b11, 6'd60, 6'd61, 5'd20, 5'd21, 1'b0);
        flush = 1'b0;
        exp_q.delete();
        n_tests++;
        if ({commit_en, full, dispatch_rob_addr} !== 5'b00001) begin
            n_fail++; $display("FAIL flush_state: got cen=%b full=%b addr=%0d want 00/0/1", commit_en, full, dispatch_rob_addr);
        end
        wb(2'b11, 2'd2, 2'd2, 1'b0, 1'b1, 2'b00);
        n_tests++;
        if (commit_en !== 2'b00) begin
            n_fail++; $display("FAIL flush_stale_wb: got cen=%b want 00", commit_en);
        end
        dispatch(2'b11, 6'd33, 6'd34, 5'd25, 5'd26, 1'b1);
        wb(2'b11, 2'd1, 2'd1, 1'b0, 1'b1, 2'b00);
        e = exp_q.pop_front();
        n_tests++;
        if ({commit_en, commit_phys_rd & pmask(e.en), commit_arch_rd & amask(e.en)} !==
            {e.en, e.phys & pmask(e.en), e.arch & amask(e.en)}) begin
            n_fail++; $display("FAIL flush_resume: got en=%b phys=%h arch=%h want en=%b phys=%h arch=%h",
                               commit_en, commit_phys_rd, commit_arch_rd, e.en, e.phys, e.arch);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_tests++;
        if ({commit_en, dispatch_rob_addr} !== 4'b0010) begin
            n_fail++; $display("FAIL flush_with_commit: got cen=%b addr=%0d want 00/2", commit_en, dispatch_rob_addr);
        end
    endtask

    task automatic test_wrap();
        exp_t       e;
        logic [1:0] m_addr;
        logic [1:0] en;
        m_addr = 2'd2;
        for (int i = 0; i < 10; i++) begin
            en = 2'($urandom_range(1, 3));
            n_tests++;
            if (dispatch_rob_addr !== m_addr) begin
                n_fail++; $display("FAIL wrap_addr%0d: got %0d want %0d", i, dispatch_rob_addr, m_addr);
            end
            dispatch(en, 6'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 1'b1);
            wb(en, m_addr, m_addr, 1'b0, 1'b1, 2'b00);
            e = exp_q.pop_front();
            n_tests++;
            if ({commit_en, commit_phys_rd & pmask(e.en), commit_arch_rd & amask(e.en)} !==
                {e.en, e.phys & pmask(e.en), e.arch & amask(e.en)}) begin
                n_fail++; $display("FAIL wrap_commit%0d: got en=%b phys=%h arch=%h want en=%b phys=%h arch=%h",
                                   i, commit_en, commit_phys_rd, commit_arch_rd, e.en, e.phys, e.arch);
            end
            m_addr = m_addr + 2'd1;
        end
        step();
        n_tests++;
        if ({commit_en, full} !== 3'b000) begin
            n_fail++; $display("FAIL wrap_empty: got cen=%b full=%b want 00/0", commit_en, full);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        step();
        test_reset();
        test_basic();
        test_full();
        test_partial_row();
        test_out_of_order();
        test_exception();
        test_flush();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
